// File: rtl/sobel_frame_sequencer.sv
// Raster-order frame walker: border pixels are emitted as 8'hE0, interior pixels get a 3x3
// window fetch, a Sobel core run and a streamed result. Optional abort port: SOBEL_SEQ_ABORT_EN.
module sobel_frame_sequencer #(
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef SOBEL_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        tap_idx,
    output logic              core_start,
    input  logic              core_done,
    input  logic [7:0]        core_pix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_pix,
    output logic              out_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0]     COL_MAX  = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] WIN_ORG  = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);

    generate
        if (IMG_W < 3 || IMG_H < 3) begin : g_size_chk
            $error("sobel_frame_sequencer: image must be at least 3x3");
        end
        if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_addr_chk
            $error("sobel_frame_sequencer: IMG_W*IMG_H does not fit ADDR_W");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, CLASSIFY, FETCH, CALC, EMIT, FIN} state_t;

    state_t            state;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [ADDR_W-1:0] pix_addr;
    logic [1:0]        tcol;
    logic              is_border, is_last, kill;

    assign is_border = (row == '0) || (row == ROW_MAX) || (col == '0) || (col == COL_MAX);
    assign is_last   = (row == ROW_MAX) && (col == COL_MAX);
`ifdef SOBEL_SEQ_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; row <= '0; col <= '0; pix_addr <= '0; tcol <= '0;
            busy <= 1'b0; done <= 1'b0; mem_rd <= 1'b0; mem_addr <= '0; tap_idx <= '0;
            core_start <= 1'b0; out_valid <= 1'b0; out_pix <= '0; out_last <= 1'b0;
        end else if (kill) begin
            state <= IDLE; row <= '0; col <= '0; pix_addr <= '0; tcol <= '0;
            busy <= 1'b0; done <= 1'b0; mem_rd <= 1'b0; mem_addr <= '0; tap_idx <= '0;
            core_start <= 1'b0; out_valid <= 1'b0; out_pix <= '0; out_last <= 1'b0;
        end else begin
            done       <= 1'b0;
            core_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    row <= '0; col <= '0; pix_addr <= '0;
                    busy  <= 1'b1;
                    state <= CLASSIFY;
                end
                CLASSIFY: if (is_border) begin
                    out_pix   <= 8'hE0;
                    out_valid <= 1'b1;
                    out_last  <= is_last;
                    state     <= EMIT;
                end else begin
                    // window origin is the pixel up-left of the centre
                    mem_rd   <= 1'b1;
                    tap_idx  <= 4'd0;
                    tcol     <= 2'd0;
                    mem_addr <= pix_addr - WIN_ORG;
                    state    <= FETCH;
                end
                FETCH: if (tap_idx == 4'd8) begin
                    mem_rd     <= 1'b0;
                    core_start <= 1'b1;
                    state      <= CALC;
                end else begin
                    tap_idx  <= tap_idx + 4'd1;
                    tcol     <= (tcol == 2'd2) ? 2'd0 : tcol + 2'd1;
                    mem_addr <= mem_addr + ((tcol == 2'd2) ? ROW_STEP : ADDR_W'(1));
                end
                CALC: if (core_done) begin
                    out_pix   <= core_pix;
                    out_valid <= 1'b1;
                    out_last  <= is_last;
                    state     <= EMIT;
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    pix_addr  <= pix_addr + 1'b1;
                    if (col == COL_MAX) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                    if (is_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        state <= CLASSIFY;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: a default-size instance for address/reset checks and a 4x4
// instance driven by a table, a random core/ready model and a raster scoreboard.
module tb_sobel_frame_sequencer;
    localparam int W = 4, H = 4, NPIX = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // default-size instance
    logic        rst_n_a, start_a, core_done_a, out_ready_a;
    logic [7:0]  core_pix_a;
    logic        busy_a, done_a, mem_rd_a, core_start_a, out_valid_a, out_last_a;
    logic [15:0] mem_addr_a;
    logic [3:0]  tap_a;
    logic [7:0]  out_pix_a;
    // 4x4 instance
    logic        rst_n_b, start_b, core_done_b, out_ready_b;
    logic [7:0]  core_pix_b;
    logic        busy_b, done_b, mem_rd_b, core_start_b, out_valid_b, out_last_b;
    logic [15:0] mem_addr_b;
    logic [3:0]  tap_b;
    logic [7:0]  out_pix_b;
`ifdef SOBEL_SEQ_ABORT_EN
    logic        abort_a, abort_b;
`endif

    sobel_frame_sequencer dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a),
`ifdef SOBEL_SEQ_ABORT_EN
        .abort(abort_a),
`endif
        .busy(busy_a), .done(done_a), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .tap_idx(tap_a),
        .core_start(core_start_a), .core_done(core_done_a), .core_pix(core_pix_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pix(out_pix_a), .out_last(out_last_a)
    );

    sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b),
`ifdef SOBEL_SEQ_ABORT_EN
        .abort(abort_b),
`endif
        .busy(busy_b), .done(done_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .tap_idx(tap_b),
        .core_start(core_start_b), .core_done(core_done_b), .core_pix(core_pix_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pix(out_pix_b), .out_last(out_last_b)
    );

    // expected output pixel n of a frame: border constant, else core value
    function automatic logic [7:0] model_pix(input int idx, input logic m5a);
        int r, c, s;
        r = idx / W;
        c = idx % W;
        s = 0;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'hE0;
        if (m5a) return 8'h5A;
        for (int k = 0; k < 9; k++) s += (r - 1 + k / 3) * W + (c - 1 + k % 3);
        return s[7:0];
    endfunction

    logic mode5a, ready_mode, tb_ready, noise;
    int   n_out = 0, n_done = 0, n_rd = 0;

    // core responder (returns byte-sum of fetched addresses) + stream scoreboard for dut_b
    initial begin
        logic       pend, last_hs, hold, rdy, kill;
        int         cnt;
        logic [7:0] wsum, val, hold_pix;
        pend = 0; last_hs = 0; hold = 0; cnt = 0; wsum = 0; val = 0; hold_pix = 0;
        core_done_b = 0; core_pix_b = 0; out_ready_b = 0;
        forever begin
            @(negedge clk);
            rdy = ready_mode ? ($urandom_range(0, 2) != 0) : tb_ready;
            out_ready_b = rdy;
            core_done_b = 0;
            kill = 0;
`ifdef SOBEL_SEQ_ABORT_EN
            kill = abort_b;
`endif
            if (!rst_n_b || kill) begin
                n_out = 0; last_hs = 0; hold = 0; pend = 0;
            end else begin
                if (mem_rd_b) begin
                    n_rd++;
                    if (tap_b == 4'd0) wsum = 0;
                    wsum += mem_addr_b[7:0];
                    chk("rd_during_emit", out_valid_b, 0);
                end
                if (pend) begin
                    if (cnt == 0) begin core_done_b = 1; core_pix_b = val; pend = 0; end
                    else cnt--;
                end else if (core_start_b) begin
                    pend = 1;
                    val  = mode5a ? 8'h5A : wsum;
                    cnt  = mode5a ? 2 : int'($urandom_range(1, 4)) - 1;
                end else if (noise && $urandom_range(0, 7) == 0) begin
                    core_done_b = 1; core_pix_b = 8'hFF;
                end
                chk("done_timing", done_b, last_hs);
                last_hs = 0;
                if (done_b) begin
                    chk("frame_count", n_out, NPIX);
                    n_done++;
                    n_out = 0;
                end
                if (hold) begin
                    chk("hold_valid", out_valid_b, 1);
                    chk("hold_pix", out_pix_b, hold_pix);
                end
                hold = 0;
                if (out_valid_b) begin
                    if (rdy) begin
                        chk("stream_pix", out_pix_b, model_pix(n_out, mode5a));
                        chk("stream_last", out_last_b, (n_out == NPIX - 1));
                        last_hs = (n_out == NPIX - 1);
                        n_out++;
                    end else begin
                        hold = 1; hold_pix = out_pix_b;
                    end
                end
            end
        end
    end

    typedef struct { int stall; logic [7:0] pix; logic last; } vec_t;
    vec_t tbl[NPIX];
    int   exp_a[9];

    initial begin
        int nd, rd0, t;
        logic [7:0] p;
        tbl = '{'{0, 8'hE0, 1'b0}, '{0, 8'hE0, 1'b0}, '{2, 8'hE0, 1'b0}, '{0, 8'hE0, 1'b0},
                '{0, 8'hE0, 1'b0}, '{10, 8'h5A, 1'b0}, '{0, 8'h5A, 1'b0}, '{0, 8'hE0, 1'b0},
                '{0, 8'hE0, 1'b0}, '{0, 8'h5A, 1'b0}, '{1, 8'h5A, 1'b0}, '{0, 8'hE0, 1'b0},
                '{0, 8'hE0, 1'b0}, '{0, 8'hE0, 1'b0}, '{0, 8'hE0, 1'b0}, '{3, 8'hE0, 1'b1}};
        exp_a = '{0, 1, 2, 224, 225, 226, 448, 449, 450};
        rst_n_a = 0; rst_n_b = 0; start_a = 0; start_b = 0;
        core_done_a = 0; core_pix_a = 0; out_ready_a = 1;
        tb_ready = 0; ready_mode = 0; mode5a = 1; noise = 0;
`ifdef SOBEL_SEQ_ABORT_EN
        abort_a = 0; abort_b = 0;
`endif
        repeat (3) step();
        chk("reset_outs_a", {busy_a, done_a, mem_rd_a, core_start_a, out_valid_a, out_last_a, tap_a, out_pix_a}, 0);
        chk("reset_addr_a", mem_addr_a, 0);
        chk("reset_outs_b", {busy_b, done_b, mem_rd_b, core_start_b, out_valid_b, out_last_b, tap_b, out_pix_b}, 0);
        rst_n_a = 1; rst_n_b = 1;
        step();

        // default size: first interior window (1,1)
        start_a = 1; step(); start_a = 0;
        chk("a_busy", busy_a, 1);
        for (t = 0; t < 3000 && !mem_rd_a; t++) step();
        chk("a_fetch_seen", mem_rd_a, 1);
        for (int k = 0; k < 9; k++) begin
            chk("a_addr", mem_addr_a, exp_a[k]);
            chk("a_tap", tap_a, k);
            chk("a_rd", mem_rd_a, 1);
            step();
        end
        chk("a_core_start", core_start_a, 1);
        chk("a_rd_off", mem_rd_a, 0);
        step();
        chk("a_core_start_pulse", core_start_a, 0);
        core_pix_a = 8'h33; core_done_a = 1; step(); core_done_a = 0;
        chk("a_out_valid", out_valid_a, 1);
        chk("a_out_pix", out_pix_a, 8'h33);
        // reset in the middle of the (1,2) window fetch
        for (t = 0; t < 20 && !mem_rd_a; t++) step();
        chk("a_fetch2_seen", mem_rd_a, 1);
        repeat (3) step();
        rst_n_a = 0; #1;
        chk("a_midrst_outs", {busy_a, done_a, mem_rd_a, core_start_a, out_valid_a, out_last_a, tap_a, out_pix_a}, 0);
        chk("a_midrst_addr", mem_addr_a, 0);
        step(); step();
        chk("a_midrst_done", done_a, 0);
        rst_n_a = 1; step();
        chk("a_idle_after_rst", {busy_a, done_a}, 0);
        start_a = 1; step(); start_a = 0;
        for (t = 0; t < 3000 && !mem_rd_a; t++) step();
        chk("a_restart_addr", {mem_rd_a, mem_addr_a, tap_a}, {1'b1, 16'd0, 4'd0});

        // 4x4 table run: constant core value, latency 3, stalls on chosen pixels
        start_b = 1; step(); start_b = 0;
        chk("b_busy", busy_b, 1);
        for (int i = 0; i < NPIX; i++) begin
            for (t = 0; t < 50 && !out_valid_b; t++) step();
            chk("tbl_valid", out_valid_b, 1);
            for (int s = 0; s < tbl[i].stall; s++) begin
                p = out_pix_b;
                step();
                chk("bp_valid", out_valid_b, 1);
                chk("bp_pix", out_pix_b, p);
                chk("bp_no_rd", mem_rd_b, 0);
            end
            chk("tbl_pix", out_pix_b, tbl[i].pix);
            chk("tbl_last", out_last_b, tbl[i].last);
            tb_ready = 1; step(); tb_ready = 0;
        end
        chk("done_after_last", {done_b, busy_b}, 2'b10);
        step();
        chk("done_one_cycle", done_b, 0);
        chk("tbl_frames", n_done, 1);

        // random ready/latency with stray core_done; start pulsed mid-fetch
        mode5a = 0; ready_mode = 1; noise = 1;
        nd = n_done;
        start_b = 1; step(); start_b = 0;
        for (t = 0; t < 400 && !mem_rd_b; t++) step();
        chk("b_fetch_seen", mem_rd_b, 1);
        start_b = 1; step(); start_b = 0;
        for (t = 0; t < 2000 && n_done < nd + 1; t++) step();
        repeat (5) step();
        chk("single_done", n_done, nd + 1);
        chk("idle_after_frame", busy_b, 0);

        // start held high: back-to-back frames
        nd = n_done; rd0 = n_rd;
        start_b = 1;
        for (t = 0; t < 6000 && n_done < nd + 3; t++) step();
        start_b = 0;
        repeat (5) step();
        chk("held_start_frames", n_done, nd + 3);
        chk("reads_per_3_frames", n_rd - rd0, 3 * 9 * (W - 2) * (H - 2));
        chk("idle_after_held", busy_b, 0);

        // reset mid-frame discards it; next frame starts from pixel 0
        nd = n_done;
        start_b = 1; step(); start_b = 0;
        for (t = 0; t < 500 && n_out < 6; t++) step();
        rst_n_b = 0; #1;
        chk("b_midrst_outs", {busy_b, done_b, mem_rd_b, core_start_b, out_valid_b, out_last_b, tap_b, out_pix_b}, 0);
        step(); step();
        rst_n_b = 1; step();
        chk("b_midrst_no_done", n_done, nd);
        start_b = 1; step(); start_b = 0;
        for (t = 0; t < 2000 && n_done < nd + 1; t++) step();
        chk("b_after_rst_frame", n_done, nd + 1);

`ifdef SOBEL_SEQ_ABORT_EN
        nd = n_done;
        start_b = 1; step(); start_b = 0;
        for (t = 0; t < 400 && !core_start_b; t++) step();
        chk("abort_calc_seen", core_start_b, 1);
        abort_b = 1; step(); abort_b = 0;
        chk("abort_outs", {busy_b, done_b, mem_rd_b, core_start_b, out_valid_b}, 0);
        repeat (10) step();
        chk("abort_no_done", n_done, nd);
        start_b = 1; step(); start_b = 0;
        for (t = 0; t < 400 && !mem_rd_b; t++) step();
        chk("abort_restart_addr", {mem_rd_b, mem_addr_b}, {1'b1, 16'd0});
        for (t = 0; t < 2000 && n_done < nd + 1; t++) step();
        chk("abort_next_frame", n_done, nd + 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
